// File: rtl/video_scanout.sv
`default_nettype none
// ============================================================================
// Module  : video_scanout
// Brief   : Raster timing generator and 1-bit bitmap serialiser fed from VRAM.
// Rev     : 1.0  initial release
// ============================================================================
module video_scanout #(
    parameter int CLK_DIV        = 4,
    parameter int H_TOTAL        = 96,
    parameter int H_SYNC         = 8,
    parameter int H_ACTIVE_START = 24,
    parameter int BYTES_PER_LINE = 8,
    parameter int V_TOTAL        = 312,
    parameter int V_SYNC         = 3,
    parameter int V_ACTIVE_START = 40,
    parameter int V_ACTIVE_LINES = 64,
    parameter int ADDR_W         = 12,
    parameter logic [ADDR_W-1:0] VRAM_BASE = 12'hF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              videoEnable,
    output logic [ADDR_W-1:0] vramAddr,
    output logic              vramRead,
    input  logic [7:0]        vramData,
    output logic              videoSync,
    output logic              videoPixel,
    output logic              frameStart,
    output logic              vblank
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_h_w   = $clog2(H_TOTAL);
    localparam int c_v_w   = $clog2(V_TOTAL);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_pre  = c_div_w'(CLK_DIV - 2);
    localparam logic [c_h_w-1:0]   c_h_last   = c_h_w'(H_TOTAL - 1);
    localparam logic [c_v_w-1:0]   c_v_last   = c_v_w'(V_TOTAL - 1);

    localparam int c_fetch_first = H_ACTIVE_START - 1;
    localparam int c_fetch_last  = c_fetch_first + 8 * (BYTES_PER_LINE - 1);
    localparam int c_h_act_end   = H_ACTIVE_START + 8 * BYTES_PER_LINE;
    localparam int c_v_act_end   = V_ACTIVE_START + V_ACTIVE_LINES;
    localparam logic [2:0] c_grp_phase = 3'(H_ACTIVE_START % 8);

    logic [c_div_w-1:0] r_div_cnt;
    logic [c_h_w-1:0]   r_h_count;
    logic [c_v_w-1:0]   r_v_count;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_read;
    logic               r_data_valid;
    logic [7:0]         r_shift;
    logic               r_pixel;
    logic               r_sync;
    logic               r_vblank;
    logic               r_frame_start;

    logic               w_pix_en;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_hs;
    logic               w_vs;
    logic               w_active_line;
    logic               w_in_window;
    logic               w_grp_start;
    logic               w_fetch_slot;
    logic [c_h_w-1:0]   w_fetch_off;
    logic [c_h_w-4:0]   w_fetch_k;
    logic [c_v_w-1:0]   w_line_idx;
    logic [ADDR_W-1:0]  w_fetch_addr;

    assign w_pix_en = (r_div_cnt == c_div_last);
    assign w_h_wrap = w_pix_en && (r_h_count == c_h_last);
    assign w_v_wrap = w_h_wrap && (r_v_count == c_v_last);

    assign w_hs          = (int'(r_h_count) < H_SYNC);
    assign w_vs          = (int'(r_v_count) < V_SYNC);
    assign w_active_line = (int'(r_v_count) >= V_ACTIVE_START) && (int'(r_v_count) < c_v_act_end);
    assign w_in_window   = w_active_line && (int'(r_h_count) >= H_ACTIVE_START)
                           && (int'(r_h_count) < c_h_act_end);
    assign w_grp_start   = (r_h_count[2:0] == c_grp_phase);

    // Slot is decoded one clk ahead so the read strobe lands registered on the pixEn clk.
    assign w_fetch_off  = r_h_count - c_h_w'(c_fetch_first);
    assign w_fetch_k    = w_fetch_off[c_h_w-1:3];
    assign w_line_idx   = r_v_count - c_v_w'(V_ACTIVE_START);
    assign w_fetch_slot = w_active_line && videoEnable && (r_div_cnt == c_div_pre)
                          && (int'(r_h_count) >= c_fetch_first)
                          && (int'(r_h_count) <= c_fetch_last)
                          && (w_fetch_off[2:0] == 3'd0);
    assign w_fetch_addr = VRAM_BASE + ADDR_W'(w_line_idx) * ADDR_W'(BYTES_PER_LINE)
                          + ADDR_W'(w_fetch_k);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_h_count <= '0;
            r_v_count <= '0;
        end else begin
            r_div_cnt <= w_pix_en ? '0 : r_div_cnt + 1'b1;
            if (w_pix_en) begin
                r_h_count <= (r_h_count == c_h_last) ? '0 : r_h_count + 1'b1;
            end
            if (w_h_wrap) begin
                r_v_count <= (r_v_count == c_v_last) ? '0 : r_v_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr        <= '0;
            r_read        <= 1'b0;
            r_data_valid  <= 1'b0;
            r_sync        <= 1'b1;
            r_vblank      <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_read        <= w_fetch_slot;
            r_data_valid  <= r_read;
            if (w_fetch_slot) begin
                r_addr <= w_fetch_addr;
            end
            r_sync        <= ~(w_hs ^ w_vs);
            r_vblank      <= ~w_active_line;
            r_frame_start <= w_v_wrap;
        end
    end

    // Pixel updates at the end of the first clk of each pixel period, so the
    // visible pixel lags the counters by one clk, aligned with videoSync.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_pixel <= 1'b0;
        end else if (!videoEnable) begin
            r_shift <= '0;
            r_pixel <= 1'b0;
        end else if (r_div_cnt == '0) begin
            if (!w_in_window) begin
                r_shift <= '0;
                r_pixel <= 1'b0;
            end else if (w_grp_start) begin
                if (r_data_valid) begin
                    r_shift <= {vramData[6:0], 1'b0};
                    r_pixel <= vramData[7];
                end else begin
                    r_shift <= '0;
                    r_pixel <= 1'b0;
                end
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_pixel <= r_shift[7];
            end
        end
    end

    assign vramAddr   = r_addr;
    assign vramRead   = r_read;
    assign videoSync  = r_sync;
    assign videoPixel = r_pixel;
    assign frameStart = r_frame_start;
    assign vblank     = r_vblank;

endmodule
`default_nettype wire

// File: tb/tb_video_scanout.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_scanout
// Brief   : Self-checking bench for video_scanout (shortened frame height).
// Rev     : 1.0  initial release
// ============================================================================
module tb_video_scanout;

    localparam int VT        = 120;
    localparam int LINE_CLKS = 4 * 96;
    localparam int FRAME     = LINE_CLKS * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        videoEnable;
    logic [11:0] vramAddr;
    logic        vramRead;
    logic [7:0]  vramData = 8'h00;
    logic        videoSync;
    logic        videoPixel;
    logic        frameStart;
    logic        vblank;

    int tests = 0;
    int fails = 0;
    int t;

    typedef struct {
        int          t;
        logic [11:0] a;
    } rd_t;
    rd_t rd_q[$];

    video_scanout #(.V_TOTAL(VT)) dut (
        .clk        (clk),
        .reset      (reset),
        .videoEnable(videoEnable),
        .vramAddr   (vramAddr),
        .vramRead   (vramRead),
        .vramData   (vramData),
        .videoSync  (videoSync),
        .videoPixel (videoPixel),
        .frameStart (frameStart),
        .vblank     (vblank)
    );

    always #5 clk = ~clk;

    // t = number of clock edges since reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) t <= 0;
        else        t <= t + 1;
    end

    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (vramRead) vramData <= mem_byte(vramAddr);
    end

    function automatic int lt(input int line, input int h, input int d);
        return line * LINE_CLKS + h * 4 + d;
    endfunction

    function automatic logic [11:0] exp_addr(input int line, input int k);
        logic [31:0] s;
        s = 32'hF00 + 32'((line - 40) * 8 + k);
        return s[11:0];
    endfunction

    function automatic bit en_at(input int x, input int drop_t, input int raise_t);
        return !(drop_t >= 0 && x >= drop_t && (raise_t < 0 || x < raise_t));
    endfunction

    task automatic wait_t(input int target);
        int guard = 0;
        while (t < target && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if (t < target) begin
            tests++; fails++;
            $display("FAIL wait_t: t=%0d never reached %0d", t, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        videoEnable = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_t(lt(40, 30, 2));
        reset = 1'b0;
        #1;
        tests++;
        if (videoPixel !== 1'b0 || vramRead !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: pixel=%b read=%b required 0 0", videoPixel, vramRead);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (videoSync !== 1'b1) begin fails++; $display("FAIL rst_sync: got %b required 1", videoSync); end
            tests++; if (videoPixel !== 1'b0) begin fails++; $display("FAIL rst_pixel: got %b required 0", videoPixel); end
            tests++; if (vramRead !== 1'b0) begin fails++; $display("FAIL rst_read: got %b required 0", vramRead); end
            tests++; if (vblank !== 1'b1) begin fails++; $display("FAIL rst_vblank: got %b required 1", vblank); end
            tests++; if (frameStart !== 1'b0) begin fails++; $display("FAIL rst_fs: got %b required 0", frameStart); end
            tests++; if (vramAddr !== 12'h000) begin fails++; $display("FAIL rst_addr: got %h required 000", vramAddr); end
        end
        reset = 1'b1;
    endtask

    task automatic test_sync_line(input int line, input logic first);
        int n_first = 0;
        int n_second = 0;
        for (int tt = lt(line, 0, 0) + 1; tt <= lt(line + 1, 0, 0); tt++) begin
            wait_t(tt);
            if (tt - lt(line, 0, 0) <= 32) n_first += (videoSync === first) ? 1 : 0;
            else                           n_second += (videoSync === ~first) ? 1 : 0;
        end
        tests++;
        if (n_first !== 32) begin
            fails++;
            $display("FAIL sync_l%0d_first: %0d clks at %b, required 32", line, n_first, first);
        end
        tests++;
        if (n_second !== 352) begin
            fails++;
            $display("FAIL sync_l%0d_rest: %0d clks at %b, required 352", line, n_second, ~first);
        end
    endtask

    task automatic test_vblank_fall();
        wait_t(lt(40, 0, 0));
        tests++;
        if (vblank !== 1'b1) begin
            fails++;
            $display("FAIL vblank_l39_end: got %b required 1", vblank);
        end
    endtask

    task automatic test_line(input int line, input int drop_t, input int raise_t);
        rd_t e;
        bit  act;
        act = (line >= 40 && line < 104);
        for (int k = 0; k < 8; k++) begin
            e.t = lt(line, 23 + 8 * k, 3);
            e.a = exp_addr(line, k);
            if (act && en_at(e.t - 1, drop_t, raise_t)) rd_q.push_back(e);
        end
        for (int tt = lt(line, 0, 0) + 1; tt <= lt(line + 1, 0, 0); tt++) begin
            int   pv, hh, vv, k;
            logic exp_pix;
            logic [7:0] b;
            wait_t(tt);
            if (vramRead === 1'b1) begin
                tests++;
                if (rd_q.size() == 0) begin
                    fails++;
                    $display("FAIL read_l%0d: unexpected read at t=%0d addr=%h, required none", line, tt, vramAddr);
                end else begin
                    e = rd_q.pop_front();
                    if (tt !== e.t || vramAddr !== e.a) begin
                        fails++;
                        $display("FAIL read_l%0d: t=%0d addr=%h, required t=%0d addr=%h", line, tt, vramAddr, e.t, e.a);
                    end
                end
            end
            pv = tt - 1;
            hh = (pv / 4) % 96;
            vv = (pv / LINE_CLKS) % VT;
            exp_pix = 1'b0;
            if (vv >= 40 && vv < 104 && hh >= 24 && hh < 88 && en_at(pv, drop_t, raise_t)) begin
                k = (hh - 24) / 8;
                if (en_at(lt(vv, 23 + 8 * k, 3) - 1, drop_t, raise_t)) begin
                    b = mem_byte(exp_addr(vv, k));
                    exp_pix = b[7 - ((hh - 24) % 8)];
                end
            end
            tests++;
            if (videoPixel !== exp_pix) begin
                fails++;
                $display("FAIL pixel_l%0d: t=%0d h=%0d got %b required %b", line, tt, hh, videoPixel, exp_pix);
            end
            tests++;
            if (vblank !== !(vv >= 40 && vv < 104)) begin
                fails++;
                $display("FAIL vblank_l%0d: t=%0d got %b required %b", line, tt, vblank, !(vv >= 40 && vv < 104));
            end
            tests++;
            if (frameStart !== 1'b0) begin
                fails++;
                $display("FAIL fs_l%0d: t=%0d got %b required 0", line, tt, frameStart);
            end
            if (tt == drop_t)  videoEnable = 1'b0;
            if (tt == raise_t) videoEnable = 1'b1;
        end
        tests++;
        if (rd_q.size() != 0) begin
            fails++;
            $display("FAIL reads_l%0d: %0d expected reads missing, required 0", line, rd_q.size());
            rd_q.delete();
        end
    endtask

    task automatic test_frame_start();
        int first_t = -1;
        int cnt = 0;
        for (int tt = t + 1; tt <= FRAME + 8; tt++) begin
            wait_t(tt);
            if (frameStart === 1'b1) begin
                cnt++;
                if (first_t < 0) first_t = tt;
            end
        end
        tests++;
        if (first_t !== FRAME) begin
            fails++;
            $display("FAIL fs_time: first pulse at %0d clks, required %0d", first_t, FRAME);
        end
        tests++;
        if (cnt !== 1) begin
            fails++;
            $display("FAIL fs_width: %0d high clks, required 1", cnt);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        videoEnable = 1'b1;
        test_reset();
        test_sync_line(0, 1'b1);
        test_sync_line(5, 1'b0);
        test_vblank_fall();
        test_line(40, -1, -1);
        test_line(50, lt(50, 40, 0), lt(50, 95, 0));
        test_line(51, -1, -1);
        test_line(103, -1, -1);
        test_line(104, -1, -1);
        test_frame_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
